load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access initiator for the RISC-V core; sits between the execute stage and data memory.
- Accepts one load/store per handshake and issues a word-aligned request with byte enables and a req/ack handshake to a variable-latency memory.
- For loads, returns the extracted, sign- or zero-extended value to the writeback stage.
- Stalls the pipeline while a request is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY before the request is abandoned; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  execute-stage op valid this cycle
- is_load  input  1  op is a load
- is_store  input  1  op is a store
- funct3  input  3  RISC-V width/sign field
- addr  input  32  effective address (alu result)
- store_data  input  32  rs2 value
- stall  output  1  hold upstream pipeline
- mem_req  output  1  memory request, held until ack
- mem_we  output  4  byte write enables (0000 = read)
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  memory completion; rdata valid same cycle
- mem_rdata  input  32  read word
- load_valid  output  1  one-cycle pulse, load_data valid
- load_data  output  32  extended load result
- op_done  output  1  one-cycle pulse at load or store completion
- bus_error  output  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE; all outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, load_data, and the counter.
- Reset mid-operation: mem_req drops at the reset edge; the outstanding op is discarded with no pulses.
- States are IDLE, BUSY and DONE.
- accept = valid_in & (is_load | is_store) in IDLE. If both is_load and is_store are high, the op is treated as a load.
- IDLE -> BUSY on accept: latch mem_addr, mem_we, mem_wdata, funct3, addr[1:0] and is_load; mem_req = 1 from the next cycle.
- BUSY:
  - mem_req held high; request fields are stable until ack.
  - On mem_ack: capture the extracted load value into load_data (loads only) and go to DONE; mem_req = 0 from the next cycle.
- DONE:
  - Lasts exactly one cycle: op_done = 1, and load_valid = 1 if the op was a load. Then -> IDLE.
  - New ops are not accepted in DONE.
- stall = accept | (state == BUSY) | (state == DONE & valid_in & (is_load | is_store)).
- Minimum latency: accept at cycle 0 -> mem_req at cycle 1; ack at cycle 1 -> load_valid at cycle 2.
- An ack in IDLE or DONE is ignored.
- Byte enables:
  - SB: 0001 << addr[1:0]
  - SH: 0011 << {addr[1],1'b0}
  - SW: 1111
  - loads: 0000
- Store data: SB {4{sd[7:0]}}; SH {2{sd[15:0]}}; SW sd.
- Load extract uses byte lane addr[1:0] or halfword lane addr[1]:
  - LB / LH sign-extend; LBU / LHU zero-extend; LW passes the word through.
  - Undefined funct3 (011, 110, 111) behaves as LW / SW.
- Timeout: a counter clears on entry to BUSY and increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES: drop mem_req, pulse bus_error for one cycle, set load_data = 0, no load_valid or op_done, go to IDLE.
- load_data holds its last value outside the load_valid pulse.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - adds output misaligned (1 bit, reset 0).
  - Applies to halfword ops with addr[0] = 1, or word ops with addr[1:0] != 0.
  - Such an op is not issued: misaligned pulses for one cycle, the state stays IDLE, and stall stays low.
- Undefined:
  - no port is added.
  - The offending low address bits are ignored: halfword uses lane addr[1]; word uses the full word.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101)
  - the state enum (IDLE, BUSY, DONE)
  - byte-enable constants
- Sub-module load_align: combinational; takes rdata, funct3 and offset[1:0], produces a 32-bit extended value. It is reused by the bench reference model.

Test Plan:
- LB at addr 0x103 with rdata 0x80FF_1234: mem_addr 0x100, mem_we 0000, ack at cycle 1 -> load_valid at cycle 2 with 0xFFFF_FF80; stall high cycles 0-1.
- LHU at addr 0x202 with rdata 0xBEEF_0000 and ack after 5 BUSY cycles: mem_req held stable for 5 cycles -> load_data 0x0000_BEEF; op_done one pulse.
- SB at addr 0x301 with sd 0x1234_56AB -> mem_we 0010, mem_wdata 0xABAB_ABAB; op_done pulse with no load_valid. SH at addr 0x302 -> mem_we 1100, mem_wdata 0x56AB_56AB.
- TIMEOUT_CYCLES = 4 with no ack -> mem_req high 4 cycles; bus_error pulse; return to IDLE; the next op is accepted normally.
- rst asserted in BUSY -> mem_req 0 at the next edge; no load_valid; a late ack is ignored.
- MISALIGN_TRAP_EN defined: LW at addr 0x102 -> misaligned pulse and mem_req stays 0. Undefined: the same op -> mem_addr 0x100, word returned.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, byte enables.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Access size comes from funct3[1:0]; 11 and 1x fall back to a full word.
   function automatic logic is_byte(input logic [2:0] f3);
      return f3[1:0] == 2'b00;
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return f3[1:0] == 2'b01;
   endfunction

   function automatic logic is_word(input logic [2:0] f3);
      return f3[1] == 1'b1;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/halfword lane from the read word and extends it.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] data_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      data_out = rdata;
      case (funct3)
         F3_B:    data_out = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_out = {24'b0, byte_sel};
         F3_H:    data_out = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_out = {16'b0, half_sel};
         default: data_out = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one op per req/ack transaction to a variable-latency memory, stalls upstream while busy.
// Optional MISALIGN_TRAP_EN adds a 'misaligned' pulse output and refuses misaligned halfword/word ops.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        mem_req,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        op_done,
   output logic        bus_error
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misaligned
`endif
);

   lsu_state_e  state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic [3:0]  mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        ld_q, ld_d;
   logic [31:0] cnt_q, cnt_d;
   logic        load_valid_q, load_valid_d;
   logic [31:0] load_data_q, load_data_d;
   logic        op_done_q, op_done_d;
   logic        bus_error_q, bus_error_d;

   logic        op_vld;
   logic        misalign;
   logic        accept;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] align_out;
   logic [31:0] cnt_inc;
   logic        timeout_hit;

   assign op_vld = valid_in & (is_load | is_store);

`ifdef MISALIGN_TRAP_EN
   logic misaligned_q, misaligned_d;
   assign misalign   = (is_half(funct3) & addr[0]) | (is_word(funct3) & (addr[1:0] != 2'b00));
   assign misaligned = misaligned_q;
`else
   assign misalign = 1'b0;
`endif

   assign accept = op_vld & (state_q == IDLE) & ~misalign;
   assign stall  = accept | (state_q == BUSY) | ((state_q == DONE) & op_vld);

   // A load wins when both op flags are set, so it never writes memory.
   always_comb begin
      be    = BE_WORD;
      wdata = store_data;
      if (is_load) begin
         be = BE_NONE;
      end else if (is_byte(funct3)) begin
         be = BE_BYTE << addr[1:0];
      end else if (is_half(funct3)) begin
         be = BE_HALF << {addr[1], 1'b0};
      end
      if (is_byte(funct3)) begin
         wdata = {4{store_data[7:0]}};
      end else if (is_half(funct3)) begin
         wdata = {2{store_data[15:0]}};
      end
   end

   load_align u_align (
      .rdata    (mem_rdata),
      .funct3   (f3_q),
      .offset   (off_q),
      .data_out (align_out)
   );

   assign cnt_inc     = cnt_q + 32'd1;
   assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt_inc == TIMEOUT_CYCLES);

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      f3_d         = f3_q;
      off_d        = off_q;
      ld_d         = ld_q;
      cnt_d        = cnt_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      op_done_d    = 1'b0;
      bus_error_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = be;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_wdata_d = wdata;
               f3_d        = funct3;
               off_d       = addr[1:0];
               ld_d        = is_load;
               cnt_d       = 32'd0;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               state_d      = DONE;
               mem_req_d    = 1'b0;
               op_done_d    = 1'b1;
               load_valid_d = ld_q;
               if (ld_q) begin
                  load_data_d = align_out;
               end
            end else if (timeout_hit) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               bus_error_d = 1'b1;
               load_data_d = 32'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign misaligned_d = op_vld & (state_q == IDLE) & misalign;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 4'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         f3_q         <= 3'b0;
         off_q        <= 2'b0;
         ld_q         <= 1'b0;
         cnt_q        <= 32'd0;
         load_valid_q <= 1'b0;
         load_data_q  <= 32'd0;
         op_done_q    <= 1'b0;
         bus_error_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         ld_q         <= ld_d;
         cnt_q        <= cnt_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
         op_done_q    <= op_done_d;
         bus_error_q  <= bus_error_d;
`ifdef MISALIGN_TRAP_EN
         misaligned_q <= misaligned_d;
`endif
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;
   assign op_done    = op_done_q;
   assign bus_error  = bus_error_q;

endmodule
